// File: rtl/bus_if_pwb.sv
// rtl/bus_if_pwb.sv - CPU-side bus interface with SPM bypass, posted write buffer and bus timeout
//
// Purpose: routes one pipeline stage's CPU accesses either to the local scratch-pad
// memory (zero latency) or to the shared arbitrated bus. Bus writes are posted into a
// WB_DEPTH-entry buffer. Bus reads wait for that buffer to drain so they stay ordered
// behind earlier writes. A bus access that gets no rdy_ within TIMEOUT cycles is aborted
// and flagged on pl_bus_err.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pl_stall, pl_flush           pipeline control in
//   pl_busy, pl_bus_err          pipeline hold / one-cycle timeout pulse out
//   cpu_addr/as_/rw/wr_data      CPU request in
//   cpu_rd_data                  CPU read data out
//   spm_addr/as_/rw/wr_data      SPM request out
//   spm_rd_data                  SPM read data in
//   bus_req_/grnt_               arbitration handshake
//   bus_addr/as_/rw/wr_data      bus request out (registered)
//   bus_rd_data, bus_rdy_        bus response in
module bus_if_pwb #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int SLV_IDX_W = 3,
  parameter int SPM_IDX   = 1,
  parameter int WB_DEPTH  = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pl_stall,
  input  logic              pl_flush,
  output logic              pl_busy,
  output logic              pl_bus_err,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [PTR_W:0]   WB_FULL = (PTR_W + 1)'(WB_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] rd_buf;
  logic [CNT_W-1:0]  cnt;
  logic              op_rd;

  logic valid, sel_spm, rd_req, full, empty;
  logic rdy_hit, to_hit, release_bus;
  logic push, pop, launch_wb, launch_rd;

  assign spm_addr    = cpu_addr;
  assign spm_rw      = cpu_rw;
  assign spm_wr_data = cpu_wr_data;

  assign valid   = !cpu_as_ && !pl_flush;
  assign sel_spm = (cpu_addr[ADDR_W-1 -: SLV_IDX_W] == SLV_IDX_W'(SPM_IDX));
  assign rd_req  = valid && !sel_spm && cpu_rw;
  assign full    = (count == WB_FULL);
  assign empty   = (count == '0);

  // The counter only advances on rdy_-high ACCESS cycles, so a match here means
  // TIMEOUT cycles have already elapsed without a response.
  assign rdy_hit     = (state == ACCESS) && !bus_rdy_;
  assign to_hit      = (state == ACCESS) && bus_rdy_ && (TIMEOUT != 0) && (cnt == TO_VAL);
  assign release_bus = rdy_hit || to_hit;

  always_comb begin
    next_state  = state;
    cpu_rd_data = '0;
    spm_as_     = 1'b1;
    pl_busy     = 1'b0;
    pl_bus_err  = to_hit;
    push        = 1'b0;
    pop         = 1'b0;
    launch_wb   = 1'b0;
    launch_rd   = 1'b0;

    case (state)
      IDLE: begin
        // Draining posted writes always wins so a read never overtakes them.
        if (!empty) begin
          launch_wb  = 1'b1;
          next_state = REQ;
        end else if (rd_req) begin
          launch_rd  = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (!bus_grnt_) next_state = ACCESS;
      end
      ACCESS: begin
        if (release_bus) begin
          if (op_rd) begin
            cpu_rd_data = rdy_hit ? bus_rd_data : '0;
            next_state  = (rdy_hit && pl_stall) ? STALL : IDLE;
          end else begin
            pop        = 1'b1;
            next_state = IDLE;
          end
        end
      end
      STALL: begin
        cpu_rd_data = rd_buf;
        if (!pl_stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (valid) begin
      if (sel_spm) begin
        if (state == IDLE) begin
          if (!pl_stall) spm_as_ = 1'b0;
          if (cpu_rw) cpu_rd_data = spm_rd_data;
        end else if (state != STALL) begin
          pl_busy = 1'b1;
        end
      end else if (!cpu_rw) begin
        if (full) pl_busy = 1'b1;
        else if (!pl_stall) push = 1'b1;
      end else begin
        if (!((state == STALL) || (state == ACCESS && op_rd && release_bus)))
          pl_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_buf      <= '0;
      cnt         <= '0;
      op_rd       <= 1'b0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
    end else begin
      state <= next_state;

      if (push) begin
        wb_addr[wr_ptr] <= cpu_addr;
        wb_data[wr_ptr] <= cpu_wr_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      // The entry stays in the buffer while on the bus; it leaves only on completion.
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (launch_wb) begin
        bus_addr    <= wb_addr[rd_ptr];
        bus_rw      <= 1'b0;
        bus_wr_data <= wb_data[rd_ptr];
        bus_req_    <= 1'b0;
        op_rd       <= 1'b0;
      end else if (launch_rd) begin
        bus_addr    <= cpu_addr;
        bus_rw      <= 1'b1;
        bus_wr_data <= '0;
        bus_req_    <= 1'b0;
        op_rd       <= 1'b1;
      end

      // Strobe only on the first ACCESS cycle.
      bus_as_ <= !(state == REQ && !bus_grnt_);

      if (state == ACCESS) begin
        if (release_bus) begin
          bus_req_    <= 1'b1;
          bus_addr    <= '0;
          bus_rw      <= 1'b1;
          bus_wr_data <= '0;
          cnt         <= '0;
          if (op_rd) rd_buf <= rdy_hit ? bus_rd_data : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bus_if_pwb.md
Name: bus_if_pwb

Overview:
- Parametrised CPU-side bus interface for one pipeline stage (IF or MEM).
- Routes CPU accesses either to the local scratch-pad memory (SPM) with zero latency, or to the shared arbitrated bus through a req_/grnt_/as_/rdy_ handshake.
- Adds two things to the base bus interface: a WB_DEPTH-entry posted write buffer, so bus writes do not stall the pipeline, and a bus-access timeout that reports an error.

Parameters:
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- SLV_IDX_W, 3, width of the slave index field; the field is the top SLV_IDX_W bits of the address.
- SPM_IDX, 1, slave index value that selects the SPM.
- WB_DEPTH, 4, number of write-buffer entries; power of 2, at least 2.
- TIMEOUT, 255, cycles to wait for rdy_ in ACCESS before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pl_stall  in  1  pipeline stall
- pl_flush  in  1  pipeline flush
- pl_busy  out  1  hold the pipeline; CPU access is not yet complete
- pl_bus_err  out  1  one-cycle pulse when a bus access times out
- cpu_addr  in  ADDR_W  CPU word address
- cpu_as_  in  1  CPU address strobe, active-low
- cpu_rw  in  1  1 = read, 0 = write
- cpu_wr_data  in  DATA_W  CPU write data
- cpu_rd_data  out  DATA_W  CPU read data
- spm_addr  out  ADDR_W  SPM address
- spm_as_  out  1  SPM strobe, active-low
- spm_rw  out  1  SPM read/write
- spm_wr_data  out  DATA_W  SPM write data
- spm_rd_data  in  DATA_W  SPM read data
- bus_req_  out  1  bus request, active-low
- bus_grnt_  in  1  bus grant, active-low
- bus_addr  out  ADDR_W  bus address
- bus_as_  out  1  bus address strobe, active-low
- bus_rw  out  1  bus read/write
- bus_wr_data  out  DATA_W  bus write data
- bus_rd_data  in  DATA_W  bus read data
- bus_rdy_  in  1  bus ready, active-low

Behaviour:
- Reset (synchronous, rst=1):
  - Engine state = IDLE; write buffer emptied; rd_buf = 0; timeout counter = 0.
  - bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0.
  - Combinational outputs settle to their defaults: cpu_rd_data=0, spm_as_=1, pl_busy=0, pl_bus_err=0.
  - Reset in the middle of an access aborts it; buffered writes are lost.
- A CPU access is valid when cpu_as_=0 and pl_flush=0. sel_spm = (cpu_addr[ADDR_W-1 -: SLV_IDX_W] == SPM_IDX).
- spm_addr, spm_rw and spm_wr_data are direct copies of the corresponding CPU inputs.
- SPM path:
  - Applies to a valid access with sel_spm, engine in IDLE, and pl_stall=0.
  - spm_as_=0 that cycle; for a read, cpu_rd_data = spm_rd_data combinationally.
  - pl_busy=0. SPM accesses do not wait on write-buffer contents.
- Bus write (valid, not sel_spm, cpu_rw=0, engine in IDLE or otherwise):
  - If the buffer is not full and pl_stall=0, push {addr, data} on that clock edge; pl_busy=0.
  - If the buffer is full, pl_busy=1 and nothing is pushed.
- Bus read (valid, not sel_spm, cpu_rw=1):
  - pl_busy=1 until the read completes.
  - The read is launched only when the engine is in IDLE and the buffer is empty. This keeps reads ordered behind earlier posted writes.
- Engine launch priority in IDLE: buffer not empty > pending bus read.
  - On launch: register bus_addr, bus_rw and bus_wr_data; bus_req_=0; go to REQ.
  - Record op_rd = 1 for a CPU read, 0 for a buffer drain.
  - The buffer pops when its entry completes in ACCESS, not at launch.
- REQ: on bus_grnt_=0, go to ACCESS; bus_as_=0 for exactly the first ACCESS cycle.
- ACCESS:
  - bus_as_ returns to 1 after the first cycle. The counter increments each cycle while bus_rdy_=1.
  - On bus_rdy_=0:
    - Release the bus: bus_req_=1, bus_addr=0, bus_rw=1, bus_wr_data=0; counter=0.
    - If op_rd: cpu_rd_data = bus_rd_data combinationally that cycle, pl_busy=0, and rd_buf captures bus_rd_data. Next state is STALL if pl_stall=1, else IDLE.
    - If not op_rd: pop the buffer; next state IDLE.
  - Timeout: when TIMEOUT != 0 and the counter reaches TIMEOUT with bus_rdy_ still 1, release the bus the same way and pulse pl_bus_err for one cycle.
    - For a read: cpu_rd_data=0 and pl_busy=0 that cycle; rd_buf=0.
    - For a write: the entry is popped (dropped).
- STALL: cpu_rd_data = rd_buf; pl_busy=0; go to IDLE when pl_stall=0.
- Flush:
  - Blocks new pushes and read launches.
  - Does not cancel a bus operation already in progress, and does not discard buffered writes, which are committed.
- Simultaneous push and pop in the same cycle: both occur and the count is unchanged. The full flag is evaluated before the pop.
- Buffer pointers are log2(WB_DEPTH) bits and wrap naturally.

Test Plan:
- SPM read, SPM_IDX=1, addr top bits = 1, spm_rd_data=0xCAFE0001 -> cpu_rd_data=0xCAFE0001 in the same cycle; pl_busy=0; bus_req_ stays 1.
- 5 back-to-back bus writes, WB_DEPTH=4, bus_grnt_ held 1 -> first 4 accepted with pl_busy=0; 5th gives pl_busy=1 until the first entry completes.
- Write 0x11 to A, then read B, with grant and rdy after 1 cycle -> write completes on the bus before the read's bus_req_; read data 0x22 appears on cpu_rd_data in the rdy_ cycle.
- Bus read with pl_stall=1 at rdy_, bus_rd_data=0x55 -> state STALL, cpu_rd_data=0x55 held until pl_stall=0, then IDLE.
- TIMEOUT=8, rdy_ never asserted on a read -> after 8 ACCESS cycles: pl_bus_err pulses once, bus_req_=1, cpu_rd_data=0, pl_busy drops.
- rst=1 for one cycle while in ACCESS with 3 entries buffered -> next cycle bus_req_=1, bus_as_=1, buffer empty, state IDLE.
